bitmask_index_encoder: RTL



---
 rtl/bitmask_index_encoder_pkg.sv | 14 +
 rtl/bitmask_index_encoder_lse.sv | 41 ++++
 rtl/bitmask_index_encoder.sv | 105 ++++++++++
 3 files changed

// File: rtl/bitmask_index_encoder_pkg.sv
// Shared constants for the bitmask index encoder.
// FSM encoding and default mask/index widths.
package bitmask_index_encoder_pkg;

  localparam int N_DEF  = 32;
  localparam int IW_DEF = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EMIT = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/bitmask_index_encoder_lse.sv
// Lowest-set-bit encoder built as a tree of 2:1 priority stages.
// Each stage prefers its low half; the chosen side sets one index bit.
module lowest_set_encoder #(
  parameter int N  = 32,
  parameter int IW = 5
) (
  input  logic [N-1:0]  PEND,
  output logic [IW-1:0] IDX,
  output logic          ANY,
  output logic [N-1:0]  ONEHOT
);

  genvar l, n;

  for (l = 0; l <= IW; l++) begin : lvl
    localparam int W = N >> l;
    logic [W-1:0]  any_v;
    logic [IW-1:0] idx_v [W];

    if (l == 0) begin : leaf
      assign any_v = PEND;
      for (n = 0; n < W; n++) begin : z
        assign idx_v[n] = '0;
      end
    end else begin : node
      localparam logic [IW-1:0] BITV = IW'(1 << (l - 1));
      for (n = 0; n < W; n++) begin : pair
        assign any_v[n] = lvl[l-1].any_v[2*n]
                        | lvl[l-1].any_v[2*n+1];
        assign idx_v[n] = lvl[l-1].any_v[2*n]
                        ? lvl[l-1].idx_v[2*n]
                        : (lvl[l-1].idx_v[2*n+1] | BITV);
      end
    end
  end

  assign IDX    = lvl[IW].idx_v[0];
  assign ANY    = lvl[IW].any_v[0];
  assign ONEHOT = PEND & (~PEND + N'(1));

endmodule

// File: rtl/bitmask_index_encoder.sv
// Sequential N-to-log2(N) encoder: emits set-bit indices lowest first,
// one per valid/ready transfer, clearing each bit as it is consumed.
module bitmask_index_encoder
  import bitmask_index_encoder_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int IW = IW_DEF
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          LOAD,
  input  logic [N-1:0]  MASK,
  output logic          BUSY,
  output logic          VALID,
  output logic [IW-1:0] IDX,
  input  logic          READY,
  output logic          DONE,
  output logic [IW:0]   COUNT
);

  state_t        state;
  state_t        nxt;
  logic [N-1:0]  pend;
  logic [IW:0]   count;
  logic [IW-1:0] enc_idx;
  logic          enc_any;
  logic [N-1:0]  enc_oh;
  logic          last;

  lowest_set_encoder #(
    .N  (N),
    .IW (IW)
  ) u_lse (
    .PEND   (pend),
    .IDX    (enc_idx),
    .ANY    (enc_any),
    .ONEHOT (enc_oh)
  );

  assign last = (pend & ~enc_oh) == '0;

  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: begin
        if (LOAD) nxt = (MASK != '0) ? S_EMIT : S_DONE;
      end
      S_EMIT: begin
        if (READY && last) nxt = S_DONE;
      end
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend  <= '0;
      count <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (LOAD) begin
            pend  <= MASK;
            count <= '0;
          end
        end
        S_EMIT: begin
          if (READY) begin
            pend  <= pend & ~enc_oh;
            count <= count + {{IW{1'b0}}, 1'b1};
          end
        end
        default: pend <= '0;
      endcase
    end
  end

  always_comb begin
    BUSY  = 1'b0;
    VALID = 1'b0;
    DONE  = 1'b0;
    IDX   = '0;
    unique case (state)
      S_EMIT: begin
        BUSY  = 1'b1;
        VALID = enc_any;
        IDX   = enc_idx;
      end
      S_DONE: begin
        BUSY = 1'b1;
        DONE = 1'b1;
      end
      default: ;
    endcase
  end

  assign COUNT = count;

endmodule
